// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
package serializer_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  // Counter must represent 0..w bits remaining.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// back-to-back words stream out with no idle bit between them.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic accept;
  logic word_end;
  logic [WIDTH-1:0] shift_next;

  assign load_ready = !hold_full_q;
  assign accept     = load_valid && load_ready;
  assign word_end   = (state_q == S_SHIFT) && bit_en && (bit_cnt_q == CNT_ONE);

  assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = load_data;
          bit_cnt_d = CNT_FULL;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (word_end) begin
          // Hold has priority; accept is impossible while hold is full.
          if (hold_full_q) begin
            shift_d     = hold_q;
            bit_cnt_d   = CNT_FULL;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d   = load_data;
            bit_cnt_d = CNT_FULL;
          end else begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end else begin
          if (bit_en) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q - CNT_ONE;
          end
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign ser_valid  = (state_q == S_SHIFT);
  assign ser_out    = ser_valid && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign frame_done = word_end;
  assign busy       = ser_valid || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: word-queue reference model, a vector table,
// directed multi-cycle sequences and a randomized phase.
module tb_bit_serializer;

  localparam int W   = 8;
  localparam bit MSB = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         bit_en;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_done;
  logic         busy;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .bit_en     (bit_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words in flight, front one is being sent, pos = bits already sent.
  logic [W-1:0] mq[$];
  int unsigned  pos = 0;

  // Samples from the most recent cycle.
  logic samp_ser, samp_valid, samp_fd, samp_ready, samp_acc;

  typedef struct {
    logic         lv;
    logic [W-1:0] ld;
    logic         be;
    logic         e_ser;
    logic         e_valid;
    logic         e_fd;
    logic         e_ready;
  } vec_t;
  vec_t tbl[10];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic model_bit();
    logic [W-1:0] cur;
    int unsigned  idx;
    if (mq.size() == 0) return 1'b0;
    cur = mq[0];
    idx = MSB ? (W - 1 - pos) : pos;
    return cur[idx];
  endfunction

  function automatic void model_step(input logic lv, input logic [W-1:0] ld, input logic be);
    bit acc = lv && (mq.size() < 2);
    if (mq.size() > 0 && be) begin
      pos++;
      if (pos == W) begin
        void'(mq.pop_front());
        pos = 0;
      end
    end
    if (acc) mq.push_back(ld);
  endfunction

  task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic be);
    @(negedge clk);
    load_valid = lv;
    load_data  = ld;
    bit_en     = be;
    #1;
    chk("ser_out",    ser_out,    model_bit());
    chk("ser_valid",  ser_valid,  mq.size() > 0);
    chk("frame_done", frame_done, (mq.size() > 0) && be && (pos == W - 1));
    chk("busy",       busy,       mq.size() > 0);
    chk("load_ready", load_ready, mq.size() < 2);
    samp_ser   = ser_out;
    samp_valid = ser_valid;
    samp_fd    = frame_done;
    samp_ready = load_ready;
    samp_acc   = lv && load_ready;
    @(posedge clk);
    model_step(lv, ld, be);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    load_valid = 1'b0;
    bit_en     = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ser_out",    ser_out,    1'b0);
    chk("rst_ser_valid",  ser_valid,  1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_load_ready", load_ready, 1'b1);
    mq.delete();
    pos = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() > 0 && n < 40) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_timeout", mq.size(), 0);
  endtask

  initial begin
    logic [15:0] bits16;
    logic [7:0]  bits8;
    int          fd_first, fd_second, fd_cnt, n;

    reset = 1'b1; load_valid = 1'b0; load_data = '0; bit_en = 1'b1;
    @(negedge clk);
    chk("reset_ser_out",    ser_out,    1'b0);
    chk("reset_ser_valid",  ser_valid,  1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_busy",       busy,       1'b0);
    chk("reset_load_ready", load_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'hFF, 1'b1);
      chk("idle_ser_out", samp_ser, 1'b0);
    end

    // Single word 8'hD0, MSB first
    tbl[0] = '{1'b1, 8'hD0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].lv, tbl[i].ld, tbl[i].be);
      chk("tbl_ser_out",    samp_ser,   tbl[i].e_ser);
      chk("tbl_ser_valid",  samp_valid, tbl[i].e_valid);
      chk("tbl_frame_done", samp_fd,    tbl[i].e_fd);
      chk("tbl_load_ready", samp_ready, tbl[i].e_ready);
    end

    // Back-to-back 8'hD0 then 8'hB4
    cycle(1'b1, 8'hD0, 1'b1);
    bits16 = '0; fd_first = -1; fd_second = -1;
    for (int i = 0; i < 16; i++) begin
      cycle(i == 0, 8'hB4, 1'b1);
      bits16 = {bits16[14:0], samp_ser};
      chk("b2b_valid", samp_valid, 1'b1);
      if (i == 1) chk("b2b_ready_low", samp_ready, 1'b0);
      if (i == 8) chk("b2b_ready_back", samp_ready, 1'b1);
      if (samp_fd) begin
        if (fd_first < 0) fd_first = i; else fd_second = i;
      end
    end
    chk("b2b_bits", bits16, 16'hD0B4);
    chk("b2b_fd_gap", fd_second - fd_first, 8);
    drain();

    // Pacing: bit_en alternates, each bit held two cycles
    cycle(1'b1, 8'hA5, 1'b1);
    bits8 = '0; fd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, i[0]);
      if (i[0]) bits8 = {bits8[6:0], samp_ser};
      if (samp_fd) fd_cnt++;
    end
    chk("pace_bits", bits8, 8'hA5);
    chk("pace_fd_count", fd_cnt, 1);
    drain();

    // New word exactly on the last-bit edge, hold empty
    cycle(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(i == 7, 8'h96, 1'b1);
      if (i == 7) chk("edge_accept", samp_acc, 1'b1);
    end
    bits8 = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("edge_valid", samp_valid, 1'b1);
      bits8 = {bits8[6:0], samp_ser};
    end
    chk("edge_bits", bits8, 8'h96);
    drain();

    // Hold full: third word stalls until hold drains
    cycle(1'b1, 8'h11, 1'b1);
    cycle(1'b1, 8'h22, 1'b1);
    n = 0;
    do begin
      cycle(1'b1, 8'h33, 1'b1);
      n++;
      if (n == 1) chk("stall_ready", samp_ready, 1'b0);
    end while (!samp_acc && n < 20);
    chk("stall_cycles", n, 8);
    drain();

    // Reset mid-word with hold loaded
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset();
    cycle(1'b1, 8'h81, 1'b1);
    bits8 = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1);
      bits8 = {bits8[6:0], samp_ser};
    end
    chk("post_reset_bits", bits8, 8'h81);
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the Mealy sequence detector: accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock onto a serial line that drives the detector's `in`. A one-word holding register lets back-to-back words stream with no idle bit between them. A `frame_done` pulse marks each completed word so the detector's `out` can be correlated with word boundaries.

## Interface
- `WIDTH`, 8, bits per word (≥2)
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `load_valid` in 1: `load_data` is valid
- `load_ready` out 1: holding register free, word can be accepted
- `load_data` in WIDTH: word to serialize
- `bit_en` in 1: advance one bit at this edge (tie 1 for one bit per clock)
- `ser_out` out 1: current serial bit, feeds detector `in`
- `ser_valid` out 1: `ser_out` carries a word bit
- `frame_done` out 1: one-cycle pulse, last bit of a word consumed
- `busy` out 1: shifter or holding register occupied

## Operation
- State: IDLE (shifter empty) or SHIFT (shifter loaded); `bit_cnt` counts bits remaining in shifter (`$clog2(WIDTH+1)` bits); `hold_full` flag plus WIDTH-bit `hold` register.
- Accept: `load_valid && load_ready` at an edge. `load_ready = !hold_full` (combinational from registered flag).
- Load routing on accept:
  - IDLE → word goes straight into shifter, `bit_cnt = WIDTH`, go SHIFT.
  - SHIFT and shifter will not empty this edge → word goes to `hold`, `hold_full = 1`.
  - SHIFT, last bit consumed this edge (`bit_en && bit_cnt == 1`), hold empty → word goes straight into shifter (no gap).
- Shift: in SHIFT with `bit_en = 1`, shifter moves one position toward the output end, `bit_cnt` decrements. `bit_en = 0` holds everything.
- Word end (`bit_en && bit_cnt == 1`): `frame_done = 1` for that cycle; then, in priority order: `hold` → shifter and `hold_full = 0`; else a same-edge accepted word → shifter; else go IDLE.
- `ser_out` = shifter bit at output end (bit WIDTH-1 if MSB_FIRST, else bit 0) while SHIFT; forced 0 in IDLE. `ser_valid = (state == SHIFT)`. `busy = (state == SHIFT) || hold_full`.
- `load_data` is ignored whenever no accept occurs; words are never dropped or duplicated.

## Timing
- Reset values: state IDLE, `bit_cnt = 0`, `hold_full = 0`, `ser_out = 0`, `ser_valid = 0`, `frame_done = 0`, `busy = 0`, `load_ready = 1`.
- Latency: word accepted at edge k → first bit on `ser_out` in the cycle after edge k.
- With `bit_en` held at 1, each bit lasts exactly one cycle; a word occupies WIDTH cycles.
- Back-to-back: with `hold` refilled before word end, words are contiguous, with no IDLE cycle and `ser_valid` held high.
- `frame_done` asserts in the cycle the last bit is presented with `bit_en = 1`, and is registered before the following edge.
- Hold full: `load_ready = 0` until the edge hold moves into the shifter; it is 1 in the next cycle.
- Reset mid-word: async clear. The partial word and `hold` are discarded, and `ser_out` drops to 0 immediately with no `frame_done`.

## Structure
- Shared package `serializer_pkg`: state enum `{S_IDLE, S_SHIFT}`; function computing `bit_cnt` width from WIDTH.
- Single module; no sub-module needed. The shift/count logic stays inline.

## Test plan
- Reset then idle: `reset = 1` for 1 cycle → all outputs at reset values, `load_ready = 1`, `ser_out = 0` for 10 cycles.
- Single word, WIDTH = 8, MSB_FIRST = 1, `bit_en = 1`: load 8'b1101_0000 → `ser_out` = 1,1,0,1,0,0,0,0 on 8 consecutive cycles. `frame_done` pulses on the 8th. A downstream detector asserts `out` on the 4th bit.
- Back-to-back: load 8'hD0 then 8'hB4 immediately → 16 contiguous valid bits 1101_0000_1011_0100. `load_ready` is low from 1 cycle after the 2nd accept until the 2nd word enters the shifter. Two `frame_done` pulses are 8 cycles apart.
- Pacing: `bit_en` toggles 1,0,1,0 with word 8'hA5 → each bit is held 2 cycles and the sequence is 1,0,1,0,0,1,0,1. `frame_done` pulses only on an enabled edge.
- Boundary: present a new word exactly on the last-bit edge with hold empty → it is accepted, there is no gap, `ser_valid` never drops. With hold full, a third `load_valid` is stalled and its data is unchanged.
- Reset mid-word: assert `reset` at bit 3 of 8'hFF, with hold loaded → outputs are 0 immediately, `busy = 0`, and there is no `frame_done`. The next loaded word serializes from its first bit.
